// File: rtl/int_dct8_pkg.sv
// -----------------------------------------------------------------------------
// int_dct8_pkg
// Shared fixed-point constants for the 8-point integer DCT / IDCT pair.
//   C3..S7          : Q15 rotation constants (cos/sin of multiples of pi/16)
//   Q15_FRAC        : fraction bits carried by rotation products
//   Q6_FRAC         : fraction bits of the coefficient domain
//   IDCT_OUT_SHIFT  : final right shift of the inverse transform
// -----------------------------------------------------------------------------
package int_dct8_pkg;

    localparam int C3 = 27246;  // cos(3*pi/16)
    localparam int S3 = 18205;  // sin(3*pi/16)
    localparam int C4 = 23170;  // cos(4*pi/16)
    localparam int C6 = 12540;  // cos(6*pi/16)
    localparam int S6 = 30274;  // sin(6*pi/16)
    localparam int C7 = 6393;   // cos(7*pi/16)
    localparam int S7 = 32138;  // sin(7*pi/16)

    localparam int Q15_FRAC = 15;
    localparam int Q6_FRAC  = 6;

    // Q15 products plus the 1/256 normalisation of the inverse transform.
    localparam int IDCT_OUT_SHIFT = Q15_FRAC + 8;

endpackage

// File: rtl/int_dct8_rot.sv
// -----------------------------------------------------------------------------
// int_dct8_rot
// Combinational plane rotation used by the 8-point DCT/IDCT:
//   p = a*C - b*S
//   q = a*S + b*C
// Ports:
//   a, b : signed IN_WIDTH operands
//   p, q : signed OUT_WIDTH results (full precision by default)
// Parameters C_VAL / S_VAL are signed constants that fit CONST_WIDTH bits.
// -----------------------------------------------------------------------------
module int_dct8_rot
    import int_dct8_pkg::*;
#(
    parameter int IN_WIDTH    = 20,
    parameter int CONST_WIDTH = 16,
    parameter int OUT_WIDTH   = IN_WIDTH + CONST_WIDTH + 1,
    parameter int C_VAL       = C4,
    parameter int S_VAL       = C4
) (
    input  logic signed [IN_WIDTH-1:0]  a,
    input  logic signed [IN_WIDTH-1:0]  b,
    output logic signed [OUT_WIDTH-1:0] p,
    output logic signed [OUT_WIDTH-1:0] q
);

    localparam logic signed [CONST_WIDTH-1:0] C_K = CONST_WIDTH'(C_VAL);
    localparam logic signed [CONST_WIDTH-1:0] S_K = CONST_WIDTH'(S_VAL);

    logic signed [OUT_WIDTH-1:0] a_x;
    logic signed [OUT_WIDTH-1:0] b_x;
    logic signed [OUT_WIDTH-1:0] c_x;
    logic signed [OUT_WIDTH-1:0] s_x;

    always_comb begin
        a_x = {{(OUT_WIDTH-IN_WIDTH){a[IN_WIDTH-1]}}, a};
        b_x = {{(OUT_WIDTH-IN_WIDTH){b[IN_WIDTH-1]}}, b};
        c_x = {{(OUT_WIDTH-CONST_WIDTH){C_K[CONST_WIDTH-1]}}, C_K};
        s_x = {{(OUT_WIDTH-CONST_WIDTH){S_K[CONST_WIDTH-1]}}, S_K};
        p   = a_x * c_x - b_x * s_x;
        q   = a_x * s_x + b_x * c_x;
    end

endmodule

// File: rtl/int_idct8.sv
// -----------------------------------------------------------------------------
// int_idct8
// Four-stage pipelined 8-point integer inverse DCT (Loeffler-style flow).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   valid_in/ready_in : input handshake (ready_in = pipeline advance enable)
//   y[0:7]            : signed Q6 DCT coefficients, natural order
//   valid_out/ready_out : output handshake
//   x[0:7]            : signed reconstructed samples (saturated)
//   sat_out           : at least one lane of the current x was clamped
// Stages: 1 rotations, 2 butterflies, 3 odd middle rotation by C4,
//         4 final butterflies + round + saturate.
// -----------------------------------------------------------------------------
module int_idct8
    import int_dct8_pkg::*;
#(
    parameter int COEF_WIDTH  = 20,
    parameter int CONST_WIDTH = 16,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic signed [COEF_WIDTH-1:0] y [0:7],
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic signed [OUT_WIDTH-1:0]  x [0:7],
    output logic                         sat_out
);

    localparam int S1W = COEF_WIDTH + CONST_WIDTH + 1;
    localparam int S2W = S1W + 1;
    localparam int S3W = S2W + 1;
    localparam int MW  = S3W + CONST_WIDTH;
    localparam int S4W = S3W + 2;

    localparam logic signed [CONST_WIDTH-1:0] C4_K = CONST_WIDTH'(C4);
    localparam logic signed [S4W-1:0] RND =
        {{(S4W-IDCT_OUT_SHIFT){1'b0}}, 1'b1, {(IDCT_OUT_SHIFT-1){1'b0}}};
    localparam logic signed [S4W-1:0] XMAX = S4W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [S4W-1:0] XMIN = -XMAX - S4W'(1);

    logic en;

    // Stage 1 combinational rotation results.
    // Even: e0=(y0+y4)C4, e1=(y0-y4)C4, e2=y2*C6-y6*S6, e3=y2*S6+y6*C6
    // Odd : o0=y1*S7+y7*C7, o1=y5*S3+y3*C3, o2=y5*C3-y3*S3, o3=y1*C7-y7*S7
    logic signed [S1W-1:0] e_c [0:3];
    logic signed [S1W-1:0] o_c [0:3];

    logic                  s1_v, s2_v, s3_v;
    logic signed [S1W-1:0] s1_e [0:3];
    logic signed [S1W-1:0] s1_o [0:3];
    logic signed [S2W-1:0] s2_a [0:3];
    logic signed [S2W-1:0] s2_b [0:3];
    logic signed [S3W-1:0] s3_a [0:3];
    logic signed [S3W-1:0] s3_d [0:3];

    logic signed [MW-1:0]  c4_x;
    logic signed [MW-1:0]  mid_sum;
    logic signed [MW-1:0]  mid_dif;

    logic signed [S4W-1:0] fsum  [0:7];
    logic signed [S4W-1:0] fsh   [0:7];
    logic signed [OUT_WIDTH-1:0] x_nxt [0:7];
    logic                  sat_nxt;

    always_comb begin
        en       = ready_out || !valid_out;
        ready_in = en;
    end

    int_dct8_rot #(.IN_WIDTH(COEF_WIDTH), .CONST_WIDTH(CONST_WIDTH), .OUT_WIDTH(S1W),
                   .C_VAL(C4), .S_VAL(C4))
        u_rot04 (.a(y[0]), .b(y[4]), .p(e_c[1]), .q(e_c[0]));

    int_dct8_rot #(.IN_WIDTH(COEF_WIDTH), .CONST_WIDTH(CONST_WIDTH), .OUT_WIDTH(S1W),
                   .C_VAL(C6), .S_VAL(S6))
        u_rot26 (.a(y[2]), .b(y[6]), .p(e_c[2]), .q(e_c[3]));

    int_dct8_rot #(.IN_WIDTH(COEF_WIDTH), .CONST_WIDTH(CONST_WIDTH), .OUT_WIDTH(S1W),
                   .C_VAL(C7), .S_VAL(S7))
        u_rot17 (.a(y[1]), .b(y[7]), .p(o_c[3]), .q(o_c[0]));

    int_dct8_rot #(.IN_WIDTH(COEF_WIDTH), .CONST_WIDTH(CONST_WIDTH), .OUT_WIDTH(S1W),
                   .C_VAL(C3), .S_VAL(S3))
        u_rot53 (.a(y[5]), .b(y[3]), .p(o_c[2]), .q(o_c[1]));

    // Stage 3 middle odd rotation: (b2+b1)*C4 gives odd term 1,
    // (b2-b1)*C4 gives the negated odd term 2 (sign folded into stage 4).
    always_comb begin
        c4_x    = MW'(C4_K);
        mid_sum = (MW'(s2_b[2]) + MW'(s2_b[1])) * c4_x;
        mid_dif = (MW'(s2_b[2]) - MW'(s2_b[1])) * c4_x;
    end

    // Stage 4: x_n = a_n + d_n and x_(7-n) = a_n - d_n, lane 2/5 sign swapped.
    always_comb begin
        fsum[0] = S4W'(s3_a[0]) + S4W'(s3_d[0]) + RND;
        fsum[7] = S4W'(s3_a[0]) - S4W'(s3_d[0]) + RND;
        fsum[1] = S4W'(s3_a[1]) + S4W'(s3_d[1]) + RND;
        fsum[6] = S4W'(s3_a[1]) - S4W'(s3_d[1]) + RND;
        fsum[2] = S4W'(s3_a[2]) - S4W'(s3_d[2]) + RND;
        fsum[5] = S4W'(s3_a[2]) + S4W'(s3_d[2]) + RND;
        fsum[3] = S4W'(s3_a[3]) + S4W'(s3_d[3]) + RND;
        fsum[4] = S4W'(s3_a[3]) - S4W'(s3_d[3]) + RND;
        sat_nxt = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fsh[i] = fsum[i] >>> IDCT_OUT_SHIFT;
            if (fsh[i] > XMAX) begin
                x_nxt[i] = OUT_WIDTH'(XMAX);
                sat_nxt  = 1'b1;
            end else if (fsh[i] < XMIN) begin
                x_nxt[i] = OUT_WIDTH'(XMIN);
                sat_nxt  = 1'b1;
            end else begin
                x_nxt[i] = OUT_WIDTH'(fsh[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            valid_out <= 1'b0;
            sat_out   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) x[i] <= '0;
        end else if (en) begin
            s1_v      <= valid_in;
            s2_v      <= s1_v;
            s3_v      <= s2_v;
            valid_out <= s3_v;

            for (int unsigned i = 0; i < 4; i++) begin
                s1_e[i] <= e_c[i];
                s1_o[i] <= o_c[i];
            end

            s2_a[0] <= S2W'(s1_e[0]) + S2W'(s1_e[3]);
            s2_a[1] <= S2W'(s1_e[1]) + S2W'(s1_e[2]);
            s2_a[2] <= S2W'(s1_e[1]) - S2W'(s1_e[2]);
            s2_a[3] <= S2W'(s1_e[0]) - S2W'(s1_e[3]);
            s2_b[0] <= S2W'(s1_o[0]) + S2W'(s1_o[1]);
            s2_b[1] <= S2W'(s1_o[0]) - S2W'(s1_o[1]);
            s2_b[2] <= S2W'(s1_o[3]) - S2W'(s1_o[2]);
            s2_b[3] <= S2W'(s1_o[3]) + S2W'(s1_o[2]);

            for (int unsigned i = 0; i < 4; i++) s3_a[i] <= S3W'(s2_a[i]);
            s3_d[0] <= S3W'(s2_b[0]);
            s3_d[1] <= S3W'(mid_sum >>> Q15_FRAC);
            s3_d[2] <= S3W'(mid_dif >>> Q15_FRAC);
            s3_d[3] <= S3W'(s2_b[3]);

            // Output lanes only load for real vectors so bubbles never
            // leave a spurious sat_out behind.
            if (s3_v) begin
                for (int unsigned i = 0; i < 8; i++) x[i] <= x_nxt[i];
                sat_out <= sat_nxt;
            end else begin
                sat_out <= 1'b0;
            end
        end
    end

endmodule
